// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline.
// Stall requests hold the requesting stage and every younger stage. A flush
// from stage m kills stages 0..m-1 for FLUSH_HOLD cycles. A flush raised while
// an older stage stalls is parked in a pending mask until it can apply.
// The block also has a stall watchdog and saturating perf counters.
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   stall_req_i         per-stage stall requests
//   flush_req_i         per-stage flush (redirect) requests
//   stall_o/bubble_o    per-stage hold / NOP-load enables (same-cycle)
//   flush_o             per-stage kill enables (same-cycle)
//   state_o             0 IDLE, 1 STALL, 2 FLUSH (classification of the current cycle)
//   stall_timeout_o     sticky watchdog flag
//   stall_cycles_o      cycles with stall_o[0]=1 (saturating)
//   flush_count_o       flush events applied (saturating)
module pipeline_hazard_ctrl #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned FLUSH_HOLD = 1,
    parameter int unsigned WDOG_LIMIT = 1024,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic [NUM_STAGES-1:0] flush_req_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic [1:0]            state_o,
    output logic                  stall_timeout_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam int unsigned N      = NUM_STAGES;
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HOLD_W = $clog2(FLUSH_HOLD + 1);
    localparam int unsigned WD_W   = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N-1:0]       mask_q, mask_d;
    logic [IDX_W-1:0]   cur_m_q, cur_m_d;
    logic [N-1:0]       pending_q, pending_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cyc_q, stall_cyc_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               hold_act;
    logic [N-1:0]       kill_hold, live_req, raw_s, older_s, above, eff, cand;
    logic [N-1:0]       new_mask, clr, stall_c, flush_c, bubble_c;
    logic               apply, acc;
    logic [IDX_W-1:0]   app_m;

    // Stall propagation, flush selection and next-state computation
    always_comb begin
        hold_act  = (hold_q != '0);
        kill_hold = hold_act ? mask_q : '0;
        // Requests from stages already being killed do not back-pressure
        live_req  = stall_req_i & ~kill_hold;

        acc   = 1'b0;
        raw_s = '0;
        for (int j = N - 1; j >= 0; j--) begin
            acc      = acc | live_req[j];
            raw_s[j] = acc;
        end
        // Stall coming from strictly older stages; a stage's own stall does not block its flush
        older_s = raw_s >> 1;

        // During a hold, requesters at or below the current flush point are being killed
        above = '1;
        for (int j = 0; j < N; j++) begin
            above[j] = !hold_act || (IDX_W'(j) > cur_m_q);
        end
        eff  = (flush_req_i | pending_q) & above;
        cand = eff & ~older_s;

        apply = 1'b0;
        app_m = '0;
        for (int j = 0; j < N; j++) begin
            if (cand[j]) begin
                apply = 1'b1;
                app_m = IDX_W'(j);
            end
        end

        new_mask = '0;
        clr      = '0;
        for (int j = 0; j < N; j++) begin
            new_mask[j] = apply && (IDX_W'(j) < app_m);
            clr[j]      = apply && (IDX_W'(j) <= app_m);
        end

        flush_c = kill_hold | new_mask;
        stall_c = raw_s & ~flush_c;
        bubble_c = '0;
        for (int j = 1; j < N; j++) begin
            bubble_c[j] = stall_c[j-1] & ~stall_c[j] & ~flush_c[j];
        end

        pending_d = eff & older_s & ~clr;
        if (apply) begin
            hold_d  = HOLD_W'(FLUSH_HOLD - 1);
            mask_d  = new_mask;
            cur_m_d = app_m;
        end else begin
            hold_d  = hold_act ? (hold_q - HOLD_W'(1)) : '0;
            mask_d  = mask_q;
            cur_m_d = cur_m_q;
        end

        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE:  state_d = apply ? ST_FLUSH : ((|raw_s) ? ST_STALL : ST_IDLE);
            ST_STALL: state_d = apply ? ST_FLUSH : ((|raw_s) ? ST_STALL : ST_IDLE);
            ST_FLUSH: state_d = (apply || hold_act) ? ST_FLUSH
                              : ((|raw_s) ? ST_STALL : ST_IDLE);
            default:  state_d = ST_IDLE;
        endcase

        // Watchdog counts consecutive stalled cycles at fetch, saturating at the limit
        wdog_d = '0;
        if (stall_c[0]) begin
            wdog_d = (wdog_q == WD_W'(WDOG_LIMIT)) ? wdog_q : (wdog_q + WD_W'(1));
        end
        timeout_d = timeout_q | (wdog_d == WD_W'(WDOG_LIMIT));

        stall_cyc_d = stall_cyc_q;
        if (stall_c[0] && (stall_cyc_q != '1)) begin
            stall_cyc_d = stall_cyc_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (apply && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            mask_q      <= '0;
            cur_m_q     <= '0;
            pending_q   <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            mask_q      <= mask_d;
            cur_m_q     <= cur_m_d;
            pending_q   <= pending_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Same-cycle enables are forced low while reset is asserted
    assign stall_o         = rst_i ? '0 : stall_c;
    assign bubble_o        = rst_i ? '0 : bubble_c;
    assign flush_o         = rst_i ? '0 : flush_c;
    assign state_o         = rst_i ? 2'd0 : 2'(state_d);
    assign stall_timeout_o = timeout_q;
    assign stall_cycles_o  = stall_cyc_q;
    assign flush_count_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (NUM_STAGES=5, FLUSH_HOLD=2, WDOG_LIMIT=8).
// The driver applies one vector per cycle at the falling edge and queues the
// hand-computed response for that cycle; the monitor samples shortly before
// the next rising edge and compares against the queue head.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0]  s;
        logic [4:0]  b;
        logic [4:0]  f;
        logic [1:0]  st;
        logic        to;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  stall_req_i = '0;
    logic [4:0]  flush_req_i = '0;
    logic [4:0]  stall_o, bubble_o, flush_o;
    logic [1:0]  state_o;
    logic        stall_timeout_o;
    logic [31:0] stall_cycles_o, flush_count_o;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    pipeline_hazard_ctrl #(
        .NUM_STAGES(5), .FLUSH_HOLD(2), .WDOG_LIMIT(8), .CNT_W(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .stall_req_i(stall_req_i), .flush_req_i(flush_req_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
        .state_o(state_o), .stall_timeout_o(stall_timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] ex);
        tests++;
        if (act !== ex) begin
            failed++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, ex);
        end
    endtask

    task automatic step(input logic r, input logic [4:0] sr, input logic [4:0] fr,
                        input logic [4:0] es, input logic [4:0] eb, input logic [4:0] ef,
                        input logic [1:0] st, input logic to,
                        input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        @(negedge clk_i);
        rst_i       = r;
        stall_req_i = sr;
        flush_req_i = fr;
        e.s = es; e.b = eb; e.f = ef; e.st = st; e.to = to; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #4;
            if (exp_q.size() > 0) begin
                cyc++;
                e = exp_q.pop_front();
                chk("stall_o",         cyc, 32'(stall_o),         32'(e.s));
                chk("bubble_o",        cyc, 32'(bubble_o),        32'(e.b));
                chk("flush_o",         cyc, 32'(flush_o),         32'(e.f));
                chk("state_o",         cyc, 32'(state_o),         32'(e.st));
                chk("stall_timeout_o", cyc, 32'(stall_timeout_o), 32'(e.to));
                chk("stall_cycles_o",  cyc, stall_cycles_o,       e.sc);
                chk("flush_count_o",   cyc, flush_count_o,        e.fc);
            end
        end
    end

    initial begin
        int budget;
        // reset held: outputs forced low even with a stall request present
        step(1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 0, 0);
        // idle
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 0, 0);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 0, 0);
        // stall from stage 3
        step(0, 5'b01000, 5'b00000, 5'b01111, 5'b10000, 5'b00000, 2'd1, 0, 0, 0);
        step(0, 5'b01000, 5'b00000, 5'b01111, 5'b10000, 5'b00000, 2'd1, 0, 1, 0);
        step(0, 5'b01000, 5'b00000, 5'b01111, 5'b10000, 5'b00000, 2'd1, 0, 2, 0);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 3, 0);
        // flush from stage 2 beats younger stall, held 2 cycles
        step(0, 5'b00010, 5'b00100, 5'b00000, 5'b00000, 5'b00011, 2'd2, 0, 3, 0);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00011, 2'd2, 0, 3, 1);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 3, 1);
        // flush deferred under older stall, applies when stall drops
        step(0, 5'b01000, 5'b00100, 5'b01111, 5'b10000, 5'b00000, 2'd1, 0, 3, 1);
        step(0, 5'b01000, 5'b00000, 5'b01111, 5'b10000, 5'b00000, 2'd1, 0, 4, 1);
        step(0, 5'b01000, 5'b00000, 5'b01111, 5'b10000, 5'b00000, 2'd1, 0, 5, 1);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00011, 2'd2, 0, 6, 1);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00011, 2'd2, 0, 6, 2);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 6, 2);
        // widening during hold; stage-1 request during hold discarded
        step(0, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00011, 2'd2, 0, 6, 2);
        step(0, 5'b00000, 5'b10010, 5'b00000, 5'b00000, 5'b01111, 2'd2, 0, 6, 3);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01111, 2'd2, 0, 6, 4);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 6, 4);
        // flush from fetch: nothing to kill but still an event
        step(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 2'd2, 0, 6, 4);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd2, 0, 6, 5);
        // same-stage stall+flush: flush applies, own stall still holds stage 2
        step(0, 5'b00100, 5'b00100, 5'b00100, 5'b01000, 5'b00011, 2'd2, 0, 6, 5);
        step(0, 5'b00100, 5'b00000, 5'b00100, 5'b01000, 5'b00011, 2'd2, 0, 6, 6);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 6, 6);
        // watchdog: 8 stalled cycles, flag appears after the 8th edge and sticks
        for (int i = 0; i < 8; i++) begin
            step(0, 5'b10000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 2'd1, 0, 32'(6 + i), 6);
        end
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 1, 14, 6);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 1, 14, 6);
        // async reset in the middle of a flush hold
        step(0, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b01111, 2'd2, 1, 14, 6);
        step(1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 0, 0);
        step(1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 0, 0);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'd0, 0, 0, 0);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        if (exp_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
